// File: rtl/lfsr_pkg.sv
`default_nettype none
// lfsr_pkg: opcodes, mode encoding and reset constants shared by the LFSR sequencer.
// Revision 1.0
package lfsr_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD_TAPS = 3'd1;
  localparam logic [2:0] OP_LOAD_SEED = 3'd2;
  localparam logic [2:0] OP_RUN       = 3'd3;
  localparam logic [2:0] OP_PAUSE     = 3'd4;
  localparam logic [2:0] OP_STEP      = 3'd5;
  localparam logic [2:0] OP_MEASURE   = 3'd6;

  typedef enum logic [1:0] {
    MODE_PAUSE   = 2'd0,
    MODE_RUN     = 2'd1,
    MODE_MEASURE = 2'd2
  } mode_e;

  localparam logic [4:0] TAPS_RESET = 5'b10100;
  localparam logic [4:0] SEED_RESET = 5'b00001;

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// lfsr_core: Galois LFSR taps/state registers and the combinational step function.
// Revision 1.0
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int LFSR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_taps,
  input  logic                 load_seed,
  input  logic                 step,
  input  logic [LFSR_BITS-1:0] data,
  output logic [LFSR_BITS-1:0] state,
  output logic [LFSR_BITS-1:0] next_state
);

  logic [LFSR_BITS-1:0] taps_q;
  logic [LFSR_BITS-1:0] state_q;

  always_comb begin
    next_state = state_q[0] ? ((state_q >> 1) ^ taps_q) : (state_q >> 1);
  end

  // A seed load takes priority over a step issued in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      taps_q  <= LFSR_BITS'(TAPS_RESET);
      state_q <= LFSR_BITS'(SEED_RESET);
    end else begin
      if (load_taps) taps_q <= data;
      if (load_seed) state_q <= data;
      else if (step) state_q <= next_state;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_sequencer.sv
`default_nettype none
// lfsr_sequencer: command-driven run/pause/step/measure controller around lfsr_core.
// Revision 1.0
module lfsr_sequencer
  import lfsr_pkg::*;
#(
  parameter int LFSR_BITS = 5,
  parameter int CLOCK_HZ  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [LFSR_BITS-1:0] cmd_data,
  output logic                 cmd_ready,
  output logic [LFSR_BITS-1:0] lfsr_state,
  output logic                 running,
  output logic                 stuck,
  output logic [LFSR_BITS:0]   period,
  output logic                 period_valid,
  output logic                 period_err
);

  localparam int DIV_W = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLOCK_HZ - 1);
  localparam logic [LFSR_BITS:0] CNT_LIMIT = {1'b1, {LFSR_BITS{1'b0}}};

  mode_e                mode_q, mode_d, saved_q, saved_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [LFSR_BITS:0]   count_q, count_d, cnt_inc;
  logic [LFSR_BITS-1:0] start_q, start_d;
  logic [LFSR_BITS:0]   period_q, period_d;
  logic                 pvalid_q, pvalid_d;
  logic                 perr_q, perr_d;

  logic                 accept, load_taps, load_seed, step;
  logic [LFSR_BITS-1:0] core_data, state, next_state;

  lfsr_core #(.LFSR_BITS(LFSR_BITS)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_taps  (load_taps),
    .load_seed  (load_seed),
    .step       (step),
    .data       (core_data),
    .state      (state),
    .next_state (next_state)
  );

  assign cmd_ready = (mode_q != MODE_MEASURE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_inc   = count_q + (LFSR_BITS+1)'(1);

  always_comb begin
    mode_d    = mode_q;
    saved_d   = saved_q;
    div_d     = div_q;
    count_d   = count_q;
    start_d   = start_q;
    period_d  = period_q;
    pvalid_d  = 1'b0;
    perr_d    = perr_q;
    load_taps = 1'b0;
    load_seed = 1'b0;
    step      = 1'b0;
    core_data = cmd_data;

    if (mode_q == MODE_MEASURE) begin
      step    = 1'b1;
      count_d = cnt_inc;
      if (next_state == start_q) begin
        period_d = cnt_inc;
        pvalid_d = 1'b1;
        mode_d   = saved_q;
        div_d    = '0;
      end else if (cnt_inc == CNT_LIMIT) begin
        period_d  = '0;
        perr_d    = 1'b1;
        pvalid_d  = 1'b1;
        load_seed = 1'b1;
        core_data = start_q;
        mode_d    = saved_q;
      end
    end else begin
      // Mode-changing commands suppress this cycle's divider tick.
      if (mode_q == MODE_RUN &&
          !(accept && (cmd_op == OP_PAUSE || cmd_op == OP_MEASURE))) begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          step  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      if (accept) begin
        case (cmd_op)
          OP_LOAD_TAPS: load_taps = 1'b1;
          OP_LOAD_SEED: begin
            load_seed = 1'b1;
            div_d     = '0;
          end
          OP_RUN: begin
            if (mode_q == MODE_PAUSE) begin
              mode_d = MODE_RUN;
              div_d  = '0;
            end
          end
          OP_PAUSE: mode_d = MODE_PAUSE;
          OP_STEP: begin
            if (mode_q == MODE_PAUSE) step = 1'b1;
          end
          OP_MEASURE: begin
            mode_d  = MODE_MEASURE;
            saved_d = mode_q;
            start_d = state;
            count_d = '0;
            perr_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_PAUSE;
      saved_q  <= MODE_PAUSE;
      div_q    <= '0;
      count_q  <= '0;
      start_q  <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      saved_q  <= saved_d;
      div_q    <= div_d;
      count_q  <= count_d;
      start_q  <= start_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign lfsr_state   = state;
  assign running      = (mode_q == MODE_RUN);
  assign stuck        = (state == '0);
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign period_err   = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_sequencer.sv
`default_nettype none
// tb_lfsr_sequencer: directed self-checking bench for lfsr_sequencer (CLOCK_HZ = 4).
// Revision 1.0
module tb_lfsr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [4:0] cmd_data = 5'd0;
  logic       cmd_ready;
  logic [4:0] lfsr_state;
  logic       running;
  logic       stuck;
  logic [5:0] period;
  logic       period_valid;
  logic       period_err;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_sequencer #(.LFSR_BITS(5), .CLOCK_HZ(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .lfsr_state   (lfsr_state),
    .running      (running),
    .stuck        (stuck),
    .period       (period),
    .period_valid (period_valid),
    .period_err   (period_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [4:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  // Counts edges until period_valid, bounded.
  task automatic wait_pv(output int n);
    n = 0;
    while (!period_valid && n < 40) begin
      tick();
      n++;
    end
    if (!period_valid) check("pv_timeout", 32'd0, 32'd1);
  endtask

  int n;

  initial begin
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", lfsr_state, 5'b00001);
    check("rst_ready", cmd_ready, 1);
    check("rst_run", running, 0);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_perr", period_err, 0);
    check("rst_stuck", stuck, 0);

    // Single steps with default taps
    cmd(3'd5, 5'd0); check("step1", lfsr_state, 5'b10100);
    cmd(3'd5, 5'd0); check("step2", lfsr_state, 5'b01010);
    cmd(3'd5, 5'd0); check("step3", lfsr_state, 5'b00101);
    cmd(3'd5, 5'd0); check("step4", lfsr_state, 5'b10110);

    // Maximal-length period
    cmd(3'd2, 5'b00001);
    cmd(3'd6, 5'd0);
    check("m1_ready_low", cmd_ready, 0);
    wait_pv(n);
    check("m1_cycles", n, 31);
    check("m1_period", period, 31);
    check("m1_err", period_err, 0);
    check("m1_state", lfsr_state, 5'b00001);
    check("m1_run", running, 0);
    check("m1_ready", cmd_ready, 1);
    tick();
    check("m1_pulse", period_valid, 0);

    // Timeout with zero taps
    cmd(3'd1, 5'b00000);
    cmd(3'd2, 5'b00001);
    cmd(3'd6, 5'd0);
    wait_pv(n);
    check("m2_cycles", n, 32);
    check("m2_period", period, 0);
    check("m2_err", period_err, 1);
    check("m2_state", lfsr_state, 5'b00001);

    // Zero state
    cmd(3'd2, 5'b00000);
    check("stuck", stuck, 1);
    cmd(3'd6, 5'd0);
    check("m3_err_clr", period_err, 0);
    wait_pv(n);
    check("m3_cycles", n, 1);
    check("m3_period", period, 1);
    check("m3_state", lfsr_state, 5'b00000);

    // RUN at divided rate
    cmd(3'd1, 5'b10100);
    cmd(3'd2, 5'b00001);
    cmd(3'd3, 5'd0);
    check("run_flag", running, 1);
    for (int i = 0; i < 3; i++) begin tick(); check("run_hold0", lfsr_state, 5'b00001); end
    tick(); check("run_step1", lfsr_state, 5'b10100);
    cmd(3'd5, 5'd0); check("run_stepnop", lfsr_state, 5'b10100);
    tick(); check("run_hold1a", lfsr_state, 5'b10100);
    tick(); check("run_hold1b", lfsr_state, 5'b10100);
    tick(); check("run_step2", lfsr_state, 5'b01010);
    cmd(3'd4, 5'd0);
    check("pause_flag", running, 0);
    for (int i = 0; i < 6; i++) begin tick(); check("pause_hold", lfsr_state, 5'b01010); end
    cmd(3'd3, 5'd0);
    for (int i = 0; i < 3; i++) begin tick(); check("resume_hold", lfsr_state, 5'b01010); end
    tick(); check("resume_step", lfsr_state, 5'b00101);
    cmd(3'd4, 5'd0);

    // Reset during MEASURE
    cmd(3'd1, 5'b10010);
    cmd(3'd2, 5'b00001);
    cmd(3'd6, 5'd0);
    repeat (9) tick();
    check("m4_busy", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", lfsr_state, 5'b00001);
    check("abort_ready", cmd_ready, 1);
    check("abort_run", running, 0);
    check("abort_pv", period_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_pv2", period_valid, 0);
    cmd(3'd5, 5'd0);
    check("abort_taps", lfsr_state, 5'b10100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
